// File: rtl/i2c_transfer_arbiter.sv
// Round-robin arbiter that hands one I2C register write at a time to the transfer controller.
// Owns the request handshake, the latched transfer fields and the completion timeout.
//
// state     | meaning
// IDLE      | waiting for any req_valid; grants and latches fields on the same edge
// SETUP     | one cycle; issues ctrl_start and clears the timer
// WAIT_DONE | waiting for ctrl_done or timeout
// RELEASE   | one-cycle gap after the done/error pulse before re-arbitration
module i2c_transfer_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [7*N_REQ-1:0] req_slave_addr,
    input  logic [8*N_REQ-1:0] req_register_addr,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_grant,
    output logic [N_REQ-1:0]   req_done,
    output logic [N_REQ-1:0]   req_error,
    output logic               ctrl_start,
    input  logic               ctrl_done,
    output logic [6:0]         slave_addr,
    output logic [7:0]         register_addr,
    output logic [7:0]         data,
    output logic               busy
);
    localparam int          IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_DONE, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] last_winner, last_winner_nxt, winner;
    logic             found;
    logic [15:0]      timer, timer_nxt;
    logic [N_REQ-1:0] grant_nxt, done_nxt, error_nxt;
    logic             start_nxt, busy_nxt;
    logic [6:0]       slave_addr_nxt;
    logic [7:0]       register_addr_nxt, data_nxt;
    int               idx;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        winner = last_winner;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_winner) + off) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        last_winner_nxt   = last_winner;
        timer_nxt         = timer;
        grant_nxt         = '0;
        done_nxt          = '0;
        error_nxt         = '0;
        start_nxt         = 1'b0;
        slave_addr_nxt    = slave_addr;
        register_addr_nxt = register_addr;
        data_nxt          = data;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt         = N_REQ'(1) << winner;
                    last_winner_nxt   = winner;
                    slave_addr_nxt    = req_slave_addr[7*int'(winner) +: 7];
                    register_addr_nxt = req_register_addr[8*int'(winner) +: 8];
                    data_nxt          = req_data[8*int'(winner) +: 8];
                    state_nxt         = SETUP;
                end
            end
            SETUP: begin
                start_nxt = 1'b1;
                timer_nxt = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (timer != 16'hFFFF) timer_nxt = timer + 16'd1;
                // A completion in the timeout cycle still counts as success.
                if (ctrl_done) begin
                    done_nxt  = N_REQ'(1) << last_winner;
                    state_nxt = RELEASE;
                end else if (timer == TIMEOUT_LAST) begin
                    error_nxt = N_REQ'(1) << last_winner;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            last_winner   <= IDX_W'(N_REQ - 1);
            timer         <= '0;
            req_grant     <= '0;
            req_done      <= '0;
            req_error     <= '0;
            ctrl_start    <= 1'b0;
            slave_addr    <= '0;
            register_addr <= '0;
            data          <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_winner   <= last_winner_nxt;
            timer         <= timer_nxt;
            req_grant     <= grant_nxt;
            req_done      <= done_nxt;
            req_error     <= error_nxt;
            ctrl_start    <= start_nxt;
            slave_addr    <= slave_addr_nxt;
            register_addr <= register_addr_nxt;
            data          <= data_nxt;
            busy          <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_i2c_transfer_arbiter.sv
// Bench for i2c_transfer_arbiter: a timestamp-level transaction model predicts every output
// cycle by cycle, and directed scenarios pin the model with hand-computed literals.
module tb_i2c_transfer_arbiter;
    localparam int N   = 4;
    localparam int TMO = 100;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_slave_addr = '0;
    logic [8*N-1:0] req_register_addr = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_grant, req_done, req_error;
    logic           ctrl_start, ctrl_done = 1'b0, busy;
    logic [6:0]     slave_addr;
    logic [7:0]     register_addr, data;

    i2c_transfer_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid),
        .req_slave_addr(req_slave_addr), .req_register_addr(req_register_addr),
        .req_data(req_data), .req_grant(req_grant), .req_done(req_done),
        .req_error(req_error), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
        .slave_addr(slave_addr), .register_addr(register_addr), .data(data), .busy(busy)
    );

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0;
    int cyc = 0;

    // Model: a transfer is described by its grant cycle G, first wait cycle W and end cycle E.
    bit         m_active = 0, m_kind_done = 0;
    int         m_G = -10, m_W = -10, m_E = -10, m_owner = 0, m_last = N - 1;
    logic [6:0] m_sa = '0;
    logic [7:0] m_ra = '0, m_d = '0;
    logic [N-1:0] exp_grant = '0, exp_done = '0, exp_err = '0;
    logic       exp_start = 0, exp_busy = 0;

    initial forever begin
        int n, nx;
        @(posedge clock);
        n = cyc;
        if (!reset) begin
            m_active = 0; m_last = N - 1; m_sa = '0; m_ra = '0; m_d = '0; m_E = -10;
        end else if (m_active && m_E == n) begin
            m_active = 0;
        end else if (!m_active) begin
            if (req_valid != '0) begin
                for (int off = N; off >= 1; off--)
                    if (req_valid[(m_last + off) % N]) m_owner = (m_last + off) % N;
                m_last = m_owner;
                m_sa = req_slave_addr[7*m_owner +: 7];
                m_ra = req_register_addr[8*m_owner +: 8];
                m_d  = req_data[8*m_owner +: 8];
                m_G = n + 1; m_W = n + 2; m_E = -10; m_active = 1;
            end
        end else if (m_E < 0 && n >= m_W) begin
            if (ctrl_done) begin
                m_E = n + 1; m_kind_done = 1;
            end else if (n - m_W == TMO - 1) begin
                m_E = n + 1; m_kind_done = 0;
            end
        end
        nx = n + 1;
        exp_grant = (m_active && nx == m_G) ? N'(1) << m_owner : '0;
        exp_start = m_active && nx == m_W;
        exp_done  = (m_active && nx == m_E && m_kind_done)  ? N'(1) << m_owner : '0;
        exp_err   = (m_active && nx == m_E && !m_kind_done) ? N'(1) << m_owner : '0;
        exp_busy  = m_active;
        cyc = nx;
    end

    int grant_log[$];
    int start_cyc = 0, err_cyc = 0, err_count = 0, done_count = 0;

    initial forever begin
        @(negedge clock);
        if (cyc >= 1) begin
            vectors++;
            if ({req_grant, req_done, req_error, ctrl_start, slave_addr, register_addr, data, busy} !==
                {exp_grant, exp_done, exp_err, exp_start, m_sa, m_ra, m_d, exp_busy}) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: actual grant=%b done=%b err=%b start=%b sa=%h ra=%h d=%h busy=%b required grant=%b done=%b err=%b start=%b sa=%h ra=%h d=%h busy=%b",
                         cyc, req_grant, req_done, req_error, ctrl_start, slave_addr, register_addr, data, busy,
                         exp_grant, exp_done, exp_err, exp_start, m_sa, m_ra, m_d, exp_busy);
            end
            for (int i = 0; i < N; i++) if (req_grant[i] === 1'b1) grant_log.push_back(i);
            if (ctrl_start === 1'b1) start_cyc = cyc;
            if (req_error !== '0) begin err_cyc = cyc; err_count++; end
            if (req_done !== '0) done_count++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic wait_start(input string nm);
        int k = 0;
        @(negedge clock);
        while (ctrl_start !== 1'b1 && k < 200) begin @(negedge clock); k++; end
        chk(nm, 32'(ctrl_start), 32'd1);
    endtask

    task automatic pulse_done();
        ctrl_done = 1'b1;
        @(negedge clock);
        ctrl_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int expected_order[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        int d0, e0, k;
        for (int i = 0; i < N; i++) begin
            req_slave_addr[7*i +: 7]    = 7'(7'h10 + i);
            req_register_addr[8*i +: 8] = 8'(8'h20 + i);
            req_data[8*i +: 8]          = 8'(8'h30 + i);
        end
        do_reset();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset grant", 32'(req_grant), 32'd0);
        chk("reset slave_addr", 32'(slave_addr), 32'd0);

        // Single request on requester 2
        req_slave_addr[14 +: 7] = 7'h48; req_register_addr[16 +: 8] = 8'h02; req_data[16 +: 8] = 8'hA5;
        req_valid = 4'b0100;
        @(negedge clock);
        chk("single grant", 32'(req_grant), 32'b0100);
        chk("single fields", {9'd0, slave_addr, register_addr, data}, {9'd0, 7'h48, 8'h02, 8'hA5});
        req_valid = '0;
        req_slave_addr[14 +: 7] = 7'h11; req_data[16 +: 8] = 8'h5A;
        @(negedge clock);
        chk("single start", 32'(ctrl_start), 32'd1);
        repeat (50) @(negedge clock);
        chk("single fields held", 32'(slave_addr), 32'h48);
        pulse_done();
        chk("single done", 32'(req_done), 32'b0100);
        @(negedge clock);
        chk("single done one cycle", 32'(req_done), 32'd0);

        // Spurious done while idle
        repeat (2) @(negedge clock);
        pulse_done();
        chk("spurious busy", 32'(busy), 32'd0);
        chk("spurious done", 32'(req_done), 32'd0);

        // Fairness
        do_reset();
        grant_log.delete();
        req_valid = 4'b1111;
        for (int t = 0; t < 9; t++) begin
            wait_start("fair start");
            if (t == 4) req_valid = 4'b1101;
            if (t == 8) req_valid = '0;
            repeat (3) @(negedge clock);
            pulse_done();
        end
        repeat (3) @(negedge clock);
        chk("fair grant count", 32'(grant_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < grant_log.size(); i++)
            chk($sformatf("fair order[%0d]", i), 32'(grant_log[i]), 32'(expected_order[i]));

        // Timeout
        do_reset();
        d0 = done_count; e0 = err_count;
        req_valid = 4'b0001;
        @(negedge clock);
        req_valid = '0;
        wait_start("timeout start");
        k = 0;
        while (req_error === '0 && k < 300) begin @(negedge clock); k++; end
        chk("timeout error pulse", 32'(req_error), 32'b0001);
        chk("timeout distance", 32'(err_cyc - start_cyc), 32'd100);
        repeat (2) @(negedge clock);
        chk("timeout busy low", 32'(busy), 32'd0);
        chk("timeout no done", 32'(done_count - d0), 32'd0);
        chk("timeout one error", 32'(err_count - e0), 32'd1);

        // Collision of done with the timeout cycle
        do_reset();
        e0 = err_count;
        req_valid = 4'b1000;
        @(negedge clock);
        req_valid = '0;
        wait_start("collision start");
        repeat (99) @(negedge clock);
        pulse_done();
        chk("collision done", 32'(req_done), 32'b1000);
        chk("collision error", 32'(req_error), 32'd0);
        repeat (2) @(negedge clock);
        chk("collision no error", 32'(err_count - e0), 32'd0);

        // Reset mid-transfer
        do_reset();
        req_valid = 4'b0001;
        @(negedge clock);
        req_valid = '0;
        wait_start("midreset start");
        repeat (5) @(negedge clock);
        req_valid = 4'b0010;
        reset = 1'b0;
        @(negedge clock);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset outputs", {req_grant, req_done, req_error, 3'd0, ctrl_start, slave_addr, register_addr, data},
            32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset regrant", 32'(req_grant), 32'b0010);
        req_valid = '0;
        wait_start("midreset start2");
        pulse_done();
        chk("midreset done", 32'(req_done), 32'b0010);
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1);
    end
endmodule
